gc_poll_scheduler: RTL and testbench

- Sequences a single-wire GameCube transceiver engine through controller bring-up and periodic polling.
- Bring-up order: probe (0x00), then origin (0x41), then steady-state poll (0x4003xx) every POLL_PERIOD cycles.
- Handles retries, disconnect detection, backoff and rumble.
- Sits between the transceiver (command/response handshake) and game logic (latched 64-bit pad state plus connected flag).

---
 rtl/gc_poll_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_gc_poll_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gc_poll_scheduler.sv
// GameCube controller scheduler: probe/origin bring-up, periodic polling,
// retry/disconnect handling with backoff, and rumble request insertion.
module gc_poll_scheduler #(
  parameter int unsigned POLL_PERIOD    = 1_000_000,
  parameter int unsigned RETRY_LIMIT    = 3,
  parameter int unsigned BACKOFF_CYCLES = 5_000_000,
  parameter int unsigned RSP_WATCHDOG   = 20_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rumble,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [23:0] cmd_data,
  output logic [1:0]  cmd_len,
  output logic [3:0]  rsp_len,
  input  logic        rsp_valid,
  input  logic        rsp_timeout,
  input  logic [79:0] rsp_data,
  output logic [63:0] pad_state,
  output logic        pad_valid,
  output logic [15:0] origin_xy,
  output logic        connected,
  output logic [7:0]  err_count
);

  localparam int unsigned TICK_W = $clog2(POLL_PERIOD + 1);
  localparam int unsigned BO_W   = $clog2(BACKOFF_CYCLES + 1);
  localparam int unsigned WD_W   = $clog2(RSP_WATCHDOG + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PROBE_ISSUE, S_PROBE_WAIT, S_ORIGIN_ISSUE, S_ORIGIN_WAIT,
    S_POLL_WAIT_TICK, S_POLL_ISSUE, S_POLL_WAIT, S_BACKOFF
  } state_t;

  state_t              r_state, w_state_n;
  logic [TICK_W-1:0]   r_tick_cnt, w_tick_cnt_n;
  logic                r_tick_pend, w_tick_pend_n;
  logic [3:0]          r_fail_cnt, w_fail_cnt_n;
  logic [WD_W-1:0]     r_wd_cnt, w_wd_cnt_n;
  logic [BO_W-1:0]     r_bo_cnt, w_bo_cnt_n;
  logic                r_cmd_valid, w_cmd_valid_n;
  logic [23:0]         r_cmd_data, w_cmd_data_n;
  logic [1:0]          r_cmd_len, w_cmd_len_n;
  logic [3:0]          r_rsp_len, w_rsp_len_n;
  logic [63:0]         r_pad_state, w_pad_state_n;
  logic                r_pad_valid, w_pad_valid_n;
  logic [15:0]         r_origin_xy, w_origin_xy_n;
  logic                r_connected, w_connected_n;
  logic [7:0]          r_err_count, w_err_count_n;
  logic                w_err_inc;

  logic w_tick, w_wd_exp, w_got, w_fail, w_xfer;
  logic w_unused;

  assign w_tick   = (r_tick_cnt == TICK_W'(POLL_PERIOD - 1));
  assign w_wd_exp = (r_wd_cnt == WD_W'(RSP_WATCHDOG - 1));
  // Timeout beats a same-cycle reply; watchdog only fires when nothing arrived.
  assign w_got    = rsp_valid & ~rsp_timeout;
  assign w_fail   = rsp_timeout | (~rsp_valid & w_wd_exp);
  assign w_xfer   = r_cmd_valid & cmd_ready;
  assign w_unused = ^rsp_data[79:64];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_tick_pend <= 1'b0;
      r_fail_cnt  <= '0;
      r_wd_cnt    <= '0;
      r_bo_cnt    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_cmd_len   <= '0;
      r_rsp_len   <= '0;
      r_pad_state <= '0;
      r_pad_valid <= 1'b0;
      r_origin_xy <= '0;
      r_connected <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_n;
      r_tick_cnt  <= w_tick_cnt_n;
      r_tick_pend <= w_tick_pend_n;
      r_fail_cnt  <= w_fail_cnt_n;
      r_wd_cnt    <= w_wd_cnt_n;
      r_bo_cnt    <= w_bo_cnt_n;
      r_cmd_valid <= w_cmd_valid_n;
      r_cmd_data  <= w_cmd_data_n;
      r_cmd_len   <= w_cmd_len_n;
      r_rsp_len   <= w_rsp_len_n;
      r_pad_state <= w_pad_state_n;
      r_pad_valid <= w_pad_valid_n;
      r_origin_xy <= w_origin_xy_n;
      r_connected <= w_connected_n;
      r_err_count <= w_err_count_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_tick_cnt_n  = w_tick ? '0 : r_tick_cnt + TICK_W'(1);
    w_tick_pend_n = r_tick_pend | w_tick;
    w_fail_cnt_n  = r_fail_cnt;
    w_wd_cnt_n    = r_wd_cnt;
    w_bo_cnt_n    = r_bo_cnt;
    w_cmd_valid_n = r_cmd_valid;
    w_cmd_data_n  = r_cmd_data;
    w_cmd_len_n   = r_cmd_len;
    w_rsp_len_n   = r_rsp_len;
    w_pad_state_n = r_pad_state;
    w_pad_valid_n = 1'b0;
    w_origin_xy_n = r_origin_xy;
    w_connected_n = r_connected;
    w_err_count_n = r_err_count;
    w_err_inc     = 1'b0;

    case (r_state)
      S_IDLE: if (enable) begin
        w_state_n     = S_PROBE_ISSUE;
        w_cmd_valid_n = 1'b1;
        w_cmd_data_n  = 24'h000000;
        w_cmd_len_n   = 2'd1;
        w_rsp_len_n   = 4'd3;
      end
      S_PROBE_ISSUE, S_ORIGIN_ISSUE, S_POLL_ISSUE: if (w_xfer) begin
        w_cmd_valid_n = 1'b0;
        w_wd_cnt_n    = '0;
        w_state_n     = (r_state == S_PROBE_ISSUE)  ? S_PROBE_WAIT :
                        (r_state == S_ORIGIN_ISSUE) ? S_ORIGIN_WAIT : S_POLL_WAIT;
      end
      S_PROBE_WAIT: begin
        w_wd_cnt_n = r_wd_cnt + WD_W'(1);
        if (w_got && rsp_data[23:16] == 8'h09) begin
          w_state_n     = S_ORIGIN_ISSUE;
          w_cmd_valid_n = 1'b1;
          w_cmd_data_n  = 24'h410000;
          w_cmd_len_n   = 2'd1;
          w_rsp_len_n   = 4'd10;
        end else if (w_got || w_fail) begin
          w_err_inc  = 1'b1;
          w_bo_cnt_n = '0;
          w_state_n  = S_BACKOFF;
        end
      end
      S_ORIGIN_WAIT: begin
        w_wd_cnt_n = r_wd_cnt + WD_W'(1);
        if (w_got) begin
          w_origin_xy_n = rsp_data[63:48];
          w_connected_n = 1'b1;
          w_fail_cnt_n  = '0;
          w_state_n     = S_POLL_WAIT_TICK;
        end else if (w_fail) begin
          w_err_inc  = 1'b1;
          w_bo_cnt_n = '0;
          w_state_n  = S_BACKOFF;
        end
      end
      S_POLL_WAIT_TICK: begin
        if (!enable) begin
          w_connected_n = 1'b0;
          w_state_n     = S_IDLE;
        end else if (r_tick_pend) begin
          // A tick landing in the consuming cycle stays pending.
          w_tick_pend_n = w_tick;
          w_state_n     = S_POLL_ISSUE;
          w_cmd_valid_n = 1'b1;
          w_cmd_data_n  = {8'h40, 8'h03, 7'b0, rumble};
          w_cmd_len_n   = 2'd3;
          w_rsp_len_n   = 4'd8;
        end
      end
      S_POLL_WAIT: begin
        w_wd_cnt_n = r_wd_cnt + WD_W'(1);
        if (w_got && rsp_data[55]) begin
          w_pad_state_n = rsp_data[63:0];
          w_pad_valid_n = 1'b1;
          w_fail_cnt_n  = '0;
          w_state_n     = S_POLL_WAIT_TICK;
        end else if (w_got || w_fail) begin
          w_err_inc = 1'b1;
          if (r_fail_cnt + 4'd1 >= 4'(RETRY_LIMIT)) begin
            w_connected_n = 1'b0;
            w_fail_cnt_n  = '0;
            w_bo_cnt_n    = '0;
            w_state_n     = S_BACKOFF;
          end else begin
            w_fail_cnt_n = r_fail_cnt + 4'd1;
            w_state_n    = S_POLL_WAIT_TICK;
          end
        end
      end
      S_BACKOFF: begin
        if (r_bo_cnt == BO_W'(BACKOFF_CYCLES - 1)) w_state_n = S_IDLE;
        else w_bo_cnt_n = r_bo_cnt + BO_W'(1);
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_err_inc && r_err_count != 8'hFF) w_err_count_n = r_err_count + 8'd1;
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_data  = r_cmd_data;
  assign cmd_len   = r_cmd_len;
  assign rsp_len   = r_rsp_len;
  assign pad_state = r_pad_state;
  assign pad_valid = r_pad_valid;
  assign origin_xy = r_origin_xy;
  assign connected = r_connected;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// Directed self-checking bench for gc_poll_scheduler with short timing parameters.
module tb_gc_poll_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        rumble = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [23:0] cmd_data;
  logic [1:0]  cmd_len;
  logic [3:0]  rsp_len;
  logic        rsp_valid = 1'b0;
  logic        rsp_timeout = 1'b0;
  logic [79:0] rsp_data = '0;
  logic [63:0] pad_state;
  logic        pad_valid;
  logic [15:0] origin_xy;
  logic        connected;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] POLL_A = 64'h0080_8080_8080_2020;
  localparam logic [63:0] POLL_B = 64'h0180_7F80_8081_1010;
  localparam logic [63:0] POLL_C = 64'h0280_6060_7070_0505;
  localparam logic [63:0] POLL_BAD = 64'h0000_8080_8080_2020;

  gc_poll_scheduler #(
    .POLL_PERIOD(1000), .RETRY_LIMIT(3), .BACKOFF_CYCLES(500), .RSP_WATCHDOG(300)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rumble(rumble),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_len(cmd_len), .rsp_len(rsp_len), .rsp_valid(rsp_valid),
    .rsp_timeout(rsp_timeout), .rsp_data(rsp_data), .pad_state(pad_state),
    .pad_valid(pad_valid), .origin_xy(origin_xy), .connected(connected),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait for a command offer, optionally stall it, then accept it.
  task automatic accept_cmd(input string tag, input logic [23:0] exp_d,
                            input logic [1:0] exp_l, input logic [3:0] exp_r,
                            input int stall);
    int n = 0;
    int bad = 0;
    while (!cmd_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) begin
      check({tag, "_offer_timeout"}, 80'(0), 80'(1));
      return;
    end
    check({tag, "_data"}, 80'(cmd_data), 80'(exp_d));
    check({tag, "_len"}, 80'(cmd_len), 80'(exp_l));
    check({tag, "_rsplen"}, 80'(rsp_len), 80'(exp_r));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!cmd_valid || cmd_data !== exp_d || cmd_len !== exp_l || rsp_len !== exp_r) bad++;
    end
    if (stall > 0) check({tag, "_stall_stable"}, 80'(bad), 80'(0));
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check({tag, "_drop"}, 80'(cmd_valid), 80'(0));
    if (stall > 0) begin
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (cmd_valid) bad++;
      end
      check({tag, "_no_dup"}, 80'(bad), 80'(0));
    end
  endtask

  task automatic respond(input logic v, input logic t, input logic [79:0] d);
    repeat (3) @(negedge clk);
    rsp_valid   = v;
    rsp_timeout = t;
    rsp_data    = d;
    @(negedge clk);
    rsp_valid   = 1'b0;
    rsp_timeout = 1'b0;
  endtask

  task automatic bring_up(input string tag, input logic [15:0] xy);
    accept_cmd({tag, "_probe"}, 24'h000000, 2'd1, 4'd3, 0);
    respond(1'b1, 1'b0, 80'h09_0000);
    accept_cmd({tag, "_origin"}, 24'h410000, 2'd1, 4'd10, 0);
    respond(1'b1, 1'b0, {16'h0000, xy, 48'h0});
    check({tag, "_origin_xy"}, 80'(origin_xy), 80'(xy));
    check({tag, "_connected"}, 80'(connected), 80'(1));
  endtask

  initial begin
    int n;
    int pv;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 80'(cmd_valid), 80'(0));
    check("rst_cmd_data", 80'(cmd_data), 80'(0));
    check("rst_lens", 80'({cmd_len, rsp_len}), 80'(0));
    check("rst_pad", 80'({pad_state, pad_valid}), 80'(0));
    check("rst_origin", 80'(origin_xy), 80'(0));
    check("rst_conn_err", 80'({connected, err_count}), 80'(0));
    reset  = 1'b0;
    enable = 1'b1;

    // Bring-up and first poll at the first tick.
    bring_up("bu1", 16'h807F);
    accept_cmd("poll1", 24'h400300, 2'd3, 4'd8, 0);
    respond(1'b1, 1'b0, 80'(POLL_A));
    check("poll1_pad_valid", 80'(pad_valid), 80'(1));
    check("poll1_pad_state", 80'(pad_state), 80'(POLL_A));
    rumble = 1'b1;
    @(negedge clk);
    check("poll1_pad_valid_1cyc", 80'(pad_valid), 80'(0));

    // Rumble plus a 50-cycle handshake stall.
    accept_cmd("poll2", 24'h400301, 2'd3, 4'd8, 50);
    rumble = 1'b0;
    respond(1'b1, 1'b0, 80'(POLL_B));
    check("poll2_pad_state", 80'(pad_state), 80'(POLL_B));

    // Three consecutive timeouts disconnect.
    for (int k = 1; k <= 3; k++) begin
      accept_cmd($sformatf("to%0d", k), 24'h400300, 2'd3, 4'd8, 0);
      respond(1'b0, 1'b1, 80'h0);
      check($sformatf("to%0d_err", k), 80'(err_count), 80'(k));
      check($sformatf("to%0d_conn", k), 80'(connected), 80'(k < 3));
    end
    check("to_pad_held", 80'(pad_state), 80'(POLL_B));
    n = 0;
    while (!cmd_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("backoff_len", 80'(n), 80'(501));
    bring_up("bu2", 16'h7F81);

    // Watchdog, then a reply with byte1 MSB clear, then one more timeout.
    accept_cmd("wd", 24'h400300, 2'd3, 4'd8, 0);
    n = 0;
    pv = 0;
    while (err_count == 8'd3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (pad_valid) pv++;
    end
    check("wd_delay", 80'(n), 80'(300));
    check("wd_err", 80'(err_count), 80'(4));
    check("wd_conn", 80'(connected), 80'(1));
    accept_cmd("bad", 24'h400300, 2'd3, 4'd8, 0);
    respond(1'b1, 1'b0, 80'(POLL_BAD));
    if (pad_valid) pv++;
    check("bad_err", 80'(err_count), 80'(5));
    check("bad_conn", 80'(connected), 80'(1));
    check("bad_pad_state", 80'(pad_state), 80'(POLL_B));
    check("fail_no_pad_valid", 80'(pv), 80'(0));
    accept_cmd("third", 24'h400300, 2'd3, 4'd8, 0);
    respond(1'b0, 1'b1, 80'h0);
    check("third_err", 80'(err_count), 80'(6));
    check("third_disconn", 80'(connected), 80'(0));

    // Disable during a poll: the poll completes, then idle.
    bring_up("bu3", 16'h8080);
    accept_cmd("dis", 24'h400300, 2'd3, 4'd8, 0);
    enable = 1'b0;
    respond(1'b1, 1'b0, 80'(POLL_C));
    check("dis_pad_valid", 80'(pad_valid), 80'(1));
    check("dis_pad_state", 80'(pad_state), 80'(POLL_C));
    @(negedge clk);
    check("dis_conn", 80'(connected), 80'(0));
    pv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_valid) pv++;
    end
    check("dis_idle", 80'(pv), 80'(0));

    // Reset asserted while waiting for the origin reply.
    enable = 1'b1;
    accept_cmd("rs_probe", 24'h000000, 2'd1, 4'd3, 0);
    respond(1'b1, 1'b0, 80'h09_0000);
    accept_cmd("rs_origin", 24'h410000, 2'd1, 4'd10, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rs_cmd", 80'({cmd_valid, cmd_data, cmd_len, rsp_len}), 80'(0));
    check("rs_pad", 80'({pad_state, pad_valid}), 80'(0));
    check("rs_origin", 80'(origin_xy), 80'(0));
    check("rs_conn_err", 80'({connected, err_count}), 80'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
